// File: rtl/wb_cmd_master.sv
// Single-outstanding command-to-Wishbone B4 pipelined master with a per-transaction
// timeout; one registered response is held until the consumer takes it.
module wb_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [31:0] cmd_adr_i,
    input  logic [31:0] cmd_dat_i,
    input  logic        cmd_we_i,
    input  logic [3:0]  cmd_sel_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_dat_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        wbm_cyc_o,
    output logic        wbm_stb_o,
    output logic        wbm_we_o,
    output logic [31:0] wbm_adr_o,
    output logic [31:0] wbm_dat_o,
    output logic [3:0]  wbm_sel_o,
    input  logic [31:0] wbm_dat_i,
    input  logic        wbm_ack_i,
    input  logic        wbm_err_i,
    input  logic        wbm_stall_i
);

    localparam int unsigned CW = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_RESP = 2'd3;

    logic [1:0]    r_state;
    logic [CW-1:0] r_cnt;
    logic [31:0]   r_adr;
    logic [31:0]   r_dat;
    logic          r_we;
    logic [3:0]    r_sel;
    logic [31:0]   r_rsp_dat;
    logic          r_rsp_err;
    logic          r_rsp_to;
    logic          w_expired;

    // With TIMEOUT_CYCLES = 0 the counter is pinned at zero and never expires.
    assign w_expired = (TIMEOUT_CYCLES != 0) && (r_cnt == TMAX);

    always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
        if (wb_rst_i) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_adr     <= '0;
            r_dat     <= '0;
            r_we      <= 1'b0;
            r_sel     <= '0;
            r_rsp_dat <= '0;
            r_rsp_err <= 1'b0;
            r_rsp_to  <= 1'b0;
        end else begin
            if ((r_state == S_REQ || r_state == S_WAIT) && r_cnt != TMAX)
                r_cnt <= r_cnt + 1'b1;
            case (r_state)
                S_IDLE: begin
                    if (cmd_valid_i) begin
                        r_adr     <= cmd_adr_i;
                        r_dat     <= cmd_dat_i;
                        r_we      <= cmd_we_i;
                        r_sel     <= cmd_sel_i;
                        r_cnt     <= '0;
                        r_rsp_dat <= '0;
                        r_rsp_err <= 1'b0;
                        r_rsp_to  <= 1'b0;
                        r_state   <= S_REQ;
                    end
                end
                S_REQ: begin
                    // ack/err cannot belong to this strobe yet, so only timeout and stall matter.
                    if (w_expired) begin
                        r_rsp_to <= 1'b1;
                        r_state  <= S_RESP;
                    end else if (!wbm_stall_i) begin
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (wbm_err_i) begin
                        r_rsp_err <= 1'b1;
                        r_rsp_dat <= '0;
                        r_state   <= S_RESP;
                    end else if (wbm_ack_i) begin
                        r_rsp_dat <= r_we ? 32'd0 : wbm_dat_i;
                        r_state   <= S_RESP;
                    end else if (w_expired) begin
                        r_rsp_to <= 1'b1;
                        r_state  <= S_RESP;
                    end
                end
                default: begin
                    if (rsp_ready_i)
                        r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign cmd_ready_o   = (r_state == S_IDLE) && !wb_rst_i;
    assign wbm_cyc_o     = (r_state == S_REQ) || (r_state == S_WAIT);
    assign wbm_stb_o     = (r_state == S_REQ);
    assign wbm_we_o      = r_we;
    assign wbm_adr_o     = r_adr;
    assign wbm_dat_o     = r_dat;
    assign wbm_sel_o     = r_sel;
    assign rsp_valid_o   = (r_state == S_RESP);
    assign rsp_dat_o     = r_rsp_dat;
    assign rsp_err_o     = r_rsp_err;
    assign rsp_timeout_o = r_rsp_to;

endmodule

// File: tb/tb_wb_cmd_master.sv
// Bench for wb_cmd_master: each transaction is planned as a timeline (stall length,
// response delay, response kind) and the expected outputs of every cycle follow from it.
module tb_wb_cmd_master;

    localparam int unsigned T = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid_i, cmd_ready_o, cmd_we_i;
    logic [31:0] cmd_adr_i, cmd_dat_i;
    logic [3:0]  cmd_sel_i;
    logic        rsp_valid_o, rsp_ready_i, rsp_err_o, rsp_timeout_o;
    logic [31:0] rsp_dat_o;
    logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
    logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i;
    logic [3:0]  wbm_sel_o;
    logic        wbm_ack_i, wbm_err_i, wbm_stall_i;

    wb_cmd_master #(.TIMEOUT_CYCLES(T)) dut (
        .wb_clk_i(clk), .wb_rst_i(rst),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_adr_i(cmd_adr_i), .cmd_dat_i(cmd_dat_i), .cmd_we_i(cmd_we_i), .cmd_sel_i(cmd_sel_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .rsp_timeout_o(rsp_timeout_o),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o), .wbm_sel_o(wbm_sel_o),
        .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_stall_i(wbm_stall_i)
    );

    always #5 clk = ~clk;

    int n_pass  = 0;
    int n_total = 0;
    event chk_ev;

    logic        e_ready, e_cyc, e_stb, e_rvalid, e_we, e_err, e_to;
    logic [31:0] e_adr, e_dat, e_rdat;
    logic [3:0]  e_sel;
    int          cur_k;
    int          obs_lat, obs_stb;
    logic [31:0] obs_dat;
    logic        obs_err, obs_to;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    endtask

    always @(chk_ev) begin
        chk("cmd_ready", 32'(cmd_ready_o), 32'(e_ready));
        chk("cyc", 32'(wbm_cyc_o), 32'(e_cyc));
        chk("stb", 32'(wbm_stb_o), 32'(e_stb));
        chk("rsp_valid", 32'(rsp_valid_o), 32'(e_rvalid));
        chk("err_and_timeout", 32'(rsp_err_o & rsp_timeout_o), 32'd0);
        if (e_cyc) begin
            chk("wbm_adr", wbm_adr_o, e_adr);
            chk("wbm_dat", wbm_dat_o, e_dat);
            chk("wbm_sel", 32'(wbm_sel_o), 32'(e_sel));
            chk("wbm_we", 32'(wbm_we_o), 32'(e_we));
        end
        if (e_rvalid) begin
            chk("rsp_dat", rsp_dat_o, e_rdat);
            chk("rsp_err", 32'(rsp_err_o), 32'(e_err));
            chk("rsp_timeout", 32'(rsp_timeout_o), 32'(e_to));
        end
        if (wbm_stb_o) obs_stb++;
        if (rsp_valid_o && obs_lat < 0) begin
            obs_lat = cur_k;
            obs_dat = rsp_dat_o;
            obs_err = rsp_err_o;
            obs_to  = rsp_timeout_o;
        end
    end

    task automatic cycle();
        -> chk_ev;
        @(posedge clk);
        #2;
    endtask

    task automatic rand_cmd();
        cmd_adr_i = $urandom;
        cmd_dat_i = $urandom;
        cmd_we_i  = 1'($urandom_range(0, 1));
        cmd_sel_i = 4'($urandom_range(0, 15));
    endtask

    // k = 0 is the capture cycle; the strobe is up from k = 1 and the slave stalls it s cycles.
    // A slave answer planned for cycle 2+s+d counts only if the counter (k-1) has not passed T.
    task automatic txn(input logic we, input logic [31:0] adr, input logic [31:0] dat,
                       input logic [3:0] sel, input int s, input int d, input int kind,
                       input logic [31:0] rdata, input int w, input int gap, input bit cv_hold);
        int  R, resp_k, stb_end;
        bit  got, er;
        resp_k = 2 + s + d;
        R = (kind != 3 && resp_k <= int'(T) + 1) ? resp_k : int'(T) + 1;
        got = (kind != 3) && (R == resp_k);
        er  = got && (kind == 1 || kind == 2);
        stb_end = (1 + s < R) ? 1 + s : R;
        obs_lat = -1;
        obs_stb = 0;
        for (int i = 0; i < gap; i++) begin
            cur_k = -1;
            cmd_valid_i = 1'b0;
            rand_cmd();
            wbm_ack_i = 1'($urandom_range(0, 1));
            wbm_err_i = 1'($urandom_range(0, 1));
            wbm_stall_i = 1'($urandom_range(0, 1));
            rsp_ready_i = 1'($urandom_range(0, 1));
            e_ready = 1'b1; e_cyc = 1'b0; e_stb = 1'b0; e_rvalid = 1'b0;
            cycle();
        end
        e_adr = adr; e_dat = dat; e_sel = sel; e_we = we;
        e_rdat = (got && !er && !we) ? rdata : 32'd0;
        e_err = er;
        e_to  = !got;
        for (int k = 0; k <= R + 1 + w; k++) begin
            cur_k = k;
            if (k == 0) begin
                cmd_valid_i = 1'b1;
                cmd_adr_i = adr; cmd_dat_i = dat; cmd_we_i = we; cmd_sel_i = sel;
            end else begin
                cmd_valid_i = cv_hold ? 1'b1 : 1'($urandom_range(0, 1));
                rand_cmd();
            end
            if (k >= 1 && k <= s) wbm_stall_i = 1'b1;
            else if (k == s + 1) wbm_stall_i = 1'b0;
            else wbm_stall_i = 1'($urandom_range(0, 1));
            wbm_dat_i = $urandom;
            if (k <= 1 + s) begin
                wbm_ack_i = 1'($urandom_range(0, 1));
                wbm_err_i = 1'($urandom_range(0, 1));
            end else if (k == resp_k && kind != 3) begin
                wbm_ack_i = (kind == 0 || kind == 2);
                wbm_err_i = (kind == 1 || kind == 2);
                wbm_dat_i = rdata;
            end else if (k <= R) begin
                wbm_ack_i = 1'b0;
                wbm_err_i = 1'b0;
            end else begin
                wbm_ack_i = 1'($urandom_range(0, 1));
                wbm_err_i = 1'($urandom_range(0, 1));
            end
            if (k <= R) rsp_ready_i = 1'($urandom_range(0, 1));
            else rsp_ready_i = (k == R + 1 + w);
            e_ready  = (k == 0);
            e_cyc    = (k >= 1 && k <= R);
            e_stb    = (k >= 1 && k <= stb_end);
            e_rvalid = (k >= R + 1 && k <= R + 1 + w);
            cycle();
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid_i = 1'b0; rsp_ready_i = 1'b0;
        wbm_ack_i = 1'b0; wbm_err_i = 1'b0; wbm_stall_i = 1'b0; wbm_dat_i = '0;
        cmd_adr_i = '0; cmd_dat_i = '0; cmd_we_i = 1'b0; cmd_sel_i = '0;
        #12;
        chk("reset_outputs", {cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_timeout_o,
                              wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o}, 32'd0);
        chk("reset_adr", wbm_adr_o, 32'd0);
        chk("reset_dat", wbm_dat_o, 32'd0);
        chk("reset_rsp_dat", rsp_dat_o, 32'd0);
        #1 rst = 1'b0;
        @(posedge clk); #2;
        chk("ready_after_reset", 32'(cmd_ready_o), 32'd1);

        // Single-cycle read, ack the cycle after strobe acceptance.
        txn(1'b0, 32'h1000_0000, 32'h0, 4'hF, 0, 0, 0, 32'hDEADBEEF, 0, 1, 1'b0);
        chk("rd_latency", 32'(obs_lat), 32'd3);
        chk("rd_data", obs_dat, 32'hDEADBEEF);
        chk("rd_stb_cycles", 32'(obs_stb), 32'd1);
        chk("rd_flags", {30'd0, obs_err, obs_to}, 32'd0);

        // Write stalled 4 cycles.
        txn(1'b1, 32'h0200_0004, 32'h1234_5678, 4'hF, 4, 0, 0, 32'hCAFEF00D, 0, 0, 1'b0);
        chk("wr_stb_cycles", 32'(obs_stb), 32'd5);
        chk("wr_data", obs_dat, 32'd0);
        chk("wr_latency", 32'(obs_lat), 32'd7);

        // No answer within T; a late ack arrives two cycles after cyc drops.
        txn(1'b0, 32'h0000_0040, 32'h0, 4'h3, 0, 9, 0, 32'h5555AAAA, 2, 0, 1'b0);
        chk("to_flag", 32'(obs_to), 32'd1);
        chk("to_data", obs_dat, 32'd0);
        chk("to_latency", 32'(obs_lat), 32'd10);

        // Ack lands exactly when the counter reaches T: the ack wins.
        txn(1'b0, 32'h0000_0080, 32'h0, 4'hF, 0, 7, 0, 32'hA5A5_0001, 0, 1, 1'b0);
        chk("edge_ack_to", 32'(obs_to), 32'd0);
        chk("edge_ack_data", obs_dat, 32'hA5A5_0001);

        // Stall longer than T: timeout while still strobing.
        txn(1'b1, 32'h0000_00C0, 32'h7777_0000, 4'h1, 9, 0, 0, 32'h0, 0, 0, 1'b0);
        chk("stall_to_stb", 32'(obs_stb), 32'd9);
        chk("stall_to_flag", 32'(obs_to), 32'd1);

        // ack and err together.
        txn(1'b0, 32'h0000_0100, 32'h0, 4'hF, 1, 2, 2, 32'h1111_2222, 0, 0, 1'b0);
        chk("both_err", 32'(obs_err), 32'd1);
        chk("both_data", obs_dat, 32'd0);

        // Consumer back-pressure with a new command waiting throughout.
        txn(1'b0, 32'h0000_0140, 32'h0, 4'hC, 0, 1, 0, 32'h0BAD_F00D, 10, 0, 1'b1);
        chk("bp_data", obs_dat, 32'h0BAD_F00D);

        // Reset pulse while waiting for the slave.
        cmd_valid_i = 1'b1; rand_cmd(); wbm_stall_i = 1'b0; wbm_ack_i = 1'b0; wbm_err_i = 1'b0;
        @(posedge clk); #2;
        cmd_valid_i = 1'b0;
        @(posedge clk); #2;
        chk("pre_reset_wait", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd2);
        #1 rst = 1'b1;
        #1;
        chk("mid_reset_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        #1 rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wbm_ack_i = 1'b1;
            rsp_ready_i = 1'b1;
            @(posedge clk); #2;
            chk("post_reset_quiet", {29'd0, rsp_valid_o, wbm_cyc_o, cmd_ready_o}, 32'd1);
        end
        wbm_ack_i = 1'b0;
        txn(1'b0, 32'h0000_0180, 32'h0, 4'hF, 0, 0, 0, 32'h600D_600D, 0, 0, 1'b0);
        chk("post_reset_txn", obs_dat, 32'h600D_600D);

        for (int n = 0; n < 200; n++) begin
            int s;
            s = ($urandom_range(0, 7) == 0) ? int'($urandom_range(6, 10)) : int'($urandom_range(0, 3));
            txn(1'($urandom_range(0, 1)), $urandom, $urandom, 4'($urandom_range(0, 15)),
                s, int'($urandom_range(0, 10)), int'($urandom_range(0, 3)), $urandom,
                int'($urandom_range(0, 4)), int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
